axi_read_demux: RTL and testbench
=================================

AXI_READ_DEMUX -- requirements
Module: axi_read_demux

Interface
REQ-001 Parameter C_ID_WIDTH, default 1: width of the R-channel ID; SHALL be >= $clog2(C_NUM_CHANNELS).
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32: beat width in bits.
REQ-003 Parameter C_NUM_CHANNELS, default 2: number of output streams; channel i carries rid == i.
REQ-004 Parameter C_FIFO_DEPTH, default 64: beats per channel FIFO; power of 2, >= 2.
REQ-005 Port aclk, input, 1: sole clock; all logic rising-edge.
REQ-006 Port areset_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port s_axi_rvalid, input, 1: read-data beat valid.
REQ-008 Port s_axi_rready, output, 1: beat accepted when high with rvalid.
REQ-009 Port s_axi_rdata, input, C_M_AXI_DATA_WIDTH: beat data.
REQ-010 Port s_axi_rlast, input, 1: last beat of a burst.
REQ-011 Port s_axi_rid, input, C_ID_WIDTH: beat's channel ID.
REQ-012 Port m_axis_tvalid, output, [C_NUM_CHANNELS]: per-channel stream valid.
REQ-013 Port m_axis_tready, input, [C_NUM_CHANNELS]: per-channel stream ready.
REQ-014 Port m_axis_tdata, output, [C_NUM_CHANNELS][C_M_AXI_DATA_WIDTH]: per-channel data.
REQ-015 Port m_axis_tlast, output, [C_NUM_CHANNELS]: copy of rlast for that beat.
REQ-016 Port fifo_count, output, [C_NUM_CHANNELS][$clog2(C_FIFO_DEPTH)+1]: per-channel occupancy.
REQ-017 Port err_overflow, output, 1: sticky; set on beat to full channel or rid >= C_NUM_CHANNELS.

Function
REQ-018 Each channel SHALL own an independent FIFO of C_FIFO_DEPTH entries storing {rlast, rdata}.
REQ-019 s_axi_rready SHALL be 1 whenever the FIFO selected by the current s_axi_rid is not full and rid < C_NUM_CHANNELS, else 0 (combinational on rid).
REQ-020 Accepted beat (rvalid & rready) SHALL be written to FIFO[rid] in that cycle; beats with one rid SHALL stay in arrival order; different rids may interleave at beat granularity.
REQ-021 Write-to-output latency SHALL be 1 cycle: beat accepted in cycle N is presented on m_axis channel rid in cycle N+1 if that FIFO was empty.
REQ-022 m_axis_tvalid[i] SHALL equal FIFO[i] non-empty; tdata/tlast SHALL hold head entry stable while tvalid & ~tready.
REQ-023 Pop SHALL occur on m_axis_tvalid[i] & m_axis_tready[i]; channels pop independently and concurrently.
REQ-024 Simultaneous push and pop on one channel SHALL leave fifo_count unchanged and be legal at full (pop frees the slot, rready stays as per REQ-019 registered-full view: full means count == C_FIFO_DEPTH before the pop).
REQ-025 Read/write pointers SHALL be $clog2(C_FIFO_DEPTH)+1 bits, wrapping modulo 2*C_FIFO_DEPTH; full = MSBs differ, rest equal; empty = pointers equal.
REQ-026 fifo_count[i] SHALL be write pointer minus read pointer, range 0..C_FIFO_DEPTH.
REQ-027 err_overflow SHALL set the cycle after s_axi_rvalid is high while rready is 0, and remain set until reset; no FIFO state changes on that beat.

Reset
REQ-028 On areset_n low, asynchronously: all pointers 0, fifo_count 0, m_axis_tvalid 0, err_overflow 0; tdata/tlast content undefined.
REQ-029 Reset asserted mid-burst SHALL discard all buffered beats; first accepted beat after release is treated as fresh data.
REQ-030 Release of areset_n SHALL be synchronous-safe: no push/pop in the first cycle after deassertion.

Configuration
REQ-031 Macro AXI_READ_DEMUX_OUT_REG_EN defined: each channel adds a registered output stage (valid/ready skid of 2 entries) after the FIFO; latency REQ-021 becomes 2 cycles; tvalid/tdata/tlast driven only from flops; full throughput retained.
REQ-032 Macro undefined: no output stage; outputs driven from FIFO head; latency 1 cycle.

Verification
REQ-033 Single beat rid=1, data 0xA5A5A5A5, rlast=1 at cycle 10, tready=1 -> m_axis_tvalid[1] high cycle 11 (12 with OUT_REG_EN), tdata 0xA5A5A5A5, tlast 1; channel 0 tvalid stays 0.
REQ-034 Interleaved beats rid 0,1,0,1 data 1,2,3,4 -> channel 0 emits 1,3; channel 1 emits 2,4, each in order.
REQ-035 C_FIFO_DEPTH=64, channel 0 tready=0, push 64 beats rid=0 -> fifo_count[0]=64, rready 0 for rid 0, rready 1 for rid 1; 65th beat held -> err_overflow=1.
REQ-036 Channel full, same cycle push rid 0 blocked and pop via tready -> count 63, next cycle push accepted, count 64.
REQ-037 Push 200 beats rid 0 with tready toggling 1/0 every cycle -> 200 beats out in order, no loss, pointers wrap correctly.
REQ-038 Assert areset_n low with 10 beats buffered -> tvalid 0 and fifo_count 0 immediately; post-release beat 0x55 emerges alone.

Source files
------------

// File: rtl/axi_read_demux.sv
// AXI read-data demultiplexer: routes R beats by rid into per-channel FIFOs feeding AXI-Stream outputs.
// Define AXI_READ_DEMUX_OUT_REG_EN to add a 2-entry registered output stage per channel (latency 2).
module axi_read_demux #(
    parameter int C_ID_WIDTH         = 1,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_CHANNELS     = 2,
    parameter int C_FIFO_DEPTH       = 64
) (
    input  logic                                                  aclk,
    input  logic                                                  areset_n,
    input  logic                                                  s_axi_rvalid,
    output logic                                                  s_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]                         s_axi_rdata,
    input  logic                                                  s_axi_rlast,
    input  logic [C_ID_WIDTH-1:0]                                 s_axi_rid,
    output logic [C_NUM_CHANNELS-1:0]                             m_axis_tvalid,
    input  logic [C_NUM_CHANNELS-1:0]                             m_axis_tready,
    output logic [C_NUM_CHANNELS-1:0][C_M_AXI_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_NUM_CHANNELS-1:0]                             m_axis_tlast,
    output logic [C_NUM_CHANNELS-1:0][$clog2(C_FIFO_DEPTH):0]     fifo_count,
    output logic                                                  err_overflow
);
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = C_M_AXI_DATA_WIDTH + 1;

    logic                      active_q;
    logic                      err_q;
    logic [PW-1:0]             wptr_q [C_NUM_CHANNELS];
    logic [PW-1:0]             rptr_q [C_NUM_CHANNELS];
    logic [EW-1:0]             mem_q  [C_NUM_CHANNELS][C_FIFO_DEPTH];
    logic [EW-1:0]             head   [C_NUM_CHANNELS];
    logic [C_NUM_CHANNELS-1:0] full;
    logic [C_NUM_CHANNELS-1:0] empty;
    logic [C_NUM_CHANNELS-1:0] push;
    logic [C_NUM_CHANNELS-1:0] pop;

    always_comb begin
        for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
            full[i]       = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                            (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
            empty[i]      = (wptr_q[i] == rptr_q[i]);
            head[i]       = mem_q[i][rptr_q[i][AW-1:0]];
            fifo_count[i] = wptr_q[i] - rptr_q[i];
        end
    end

    // An rid matching no channel leaves rready low; active_q blocks traffic in the first cycle after reset.
    always_comb begin
        s_axi_rready = 1'b0;
        push         = '0;
        for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
            if (s_axi_rid == C_ID_WIDTH'(i)) begin
                s_axi_rready = active_q & ~full[i];
                push[i]      = active_q & ~full[i] & s_axi_rvalid;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            active_q <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
        end else begin
            active_q <= 1'b1;
            if (active_q && s_axi_rvalid && !s_axi_rready)
                err_q <= 1'b1;
            for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
                wptr_q[i] <= wptr_q[i] + PW'(push[i]);
                rptr_q[i] <= rptr_q[i] + PW'(pop[i]);
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
            if (push[i])
                mem_q[i][wptr_q[i][AW-1:0]] <= {s_axi_rlast, s_axi_rdata};
        end
    end

    assign err_overflow = err_q;

`ifdef AXI_READ_DEMUX_OUT_REG_EN
    logic [EW-1:0] sd_q [C_NUM_CHANNELS][2];
    logic [EW-1:0] sd_d [C_NUM_CHANNELS][2];
    logic [1:0]    sc_q [C_NUM_CHANNELS];
    logic [1:0]    sc_d [C_NUM_CHANNELS];

    // Entry 0 always drives the outputs; an output pop shifts entry 1 down before the refill lands.
    always_comb begin
        for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
            sd_d[i][0] = sd_q[i][0];
            sd_d[i][1] = sd_q[i][1];
            sc_d[i]    = sc_q[i];
            pop[i]     = ~empty[i] & (sc_q[i] != 2'd2);
            if ((sc_q[i] != 2'd0) && m_axis_tready[i]) begin
                sd_d[i][0] = sd_q[i][1];
                sc_d[i]    = sc_q[i] - 2'd1;
            end
            if (pop[i]) begin
                sd_d[i][sc_d[i][0]] = head[i];
                sc_d[i]             = sc_d[i] + 2'd1;
            end
            m_axis_tvalid[i] = (sc_q[i] != 2'd0);
            m_axis_tdata[i]  = sd_q[i][0][C_M_AXI_DATA_WIDTH-1:0];
            m_axis_tlast[i]  = sd_q[i][0][EW-1];
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int unsigned i = 0; i < C_NUM_CHANNELS; i++)
                sc_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < C_NUM_CHANNELS; i++)
                sc_q[i] <= sc_d[i];
        end
    end

    always_ff @(posedge aclk) begin
        for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
            sd_q[i][0] <= sd_d[i][0];
            sd_q[i][1] <= sd_d[i][1];
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
            m_axis_tvalid[i] = ~empty[i];
            m_axis_tdata[i]  = head[i][C_M_AXI_DATA_WIDTH-1:0];
            m_axis_tlast[i]  = head[i][EW-1];
            pop[i]           = active_q & ~empty[i] & m_axis_tready[i];
        end
    end
`endif

endmodule

// File: tb/tb_axi_read_demux.sv
// Scoreboard bench for axi_read_demux: directed vectors, per-channel expected queues checked by a monitor.
module tb_axi_read_demux;
    logic             aclk;
    logic             areset_n;
    logic             s_axi_rvalid;
    logic             s_axi_rready;
    logic [31:0]      s_axi_rdata;
    logic             s_axi_rlast;
    logic [0:0]       s_axi_rid;
    logic [1:0]       m_axis_tvalid;
    logic [1:0]       m_axis_tready;
    logic [1:0][31:0] m_axis_tdata;
    logic [1:0]       m_axis_tlast;
    logic [1:0][6:0]  fifo_count;
    logic             err_overflow;

    int total = 0;
    int bad   = 0;
    int out_cnt [2];
    logic [32:0] expq [2][$];

    axi_read_demux #(
        .C_ID_WIDTH(1),
        .C_M_AXI_DATA_WIDTH(32),
        .C_NUM_CHANNELS(2),
        .C_FIFO_DEPTH(64)
    ) dut (
        .aclk(aclk),
        .areset_n(areset_n),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata),
        .s_axi_rlast(s_axi_rlast),
        .s_axi_rid(s_axi_rid),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .fifo_count(fifo_count),
        .err_overflow(err_overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake on a channel pops and compares that channel's expected head.
    always @(negedge aclk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (areset_n && m_axis_tvalid[ch] && m_axis_tready[ch]) begin
                total++;
                if (expq[ch].size() == 0) begin
                    bad++;
                    $display("FAIL ch%0d unexpected beat: got %0h expected none", ch,
                             {m_axis_tlast[ch], m_axis_tdata[ch]});
                end else begin
                    logic [32:0] e;
                    e = expq[ch].pop_front();
                    if ({m_axis_tlast[ch], m_axis_tdata[ch]} !== e) begin
                        bad++;
                        $display("FAIL ch%0d beat: got %0h expected %0h", ch,
                                 {m_axis_tlast[ch], m_axis_tdata[ch]}, e);
                    end
                end
                out_cnt[ch]++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input int rid, input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_axi_rvalid = 1'b1;
        s_axi_rid    = 1'(rid);
        s_axi_rdata  = d;
        s_axi_rlast  = l;
        @(negedge aclk);
        while (!s_axi_rready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!s_axi_rready) begin
            total++;
            bad++;
            $display("FAIL send timeout: got rready 0 expected 1 (rid %0d data %0h)", rid, d);
        end else begin
            expq[rid].push_back({l, d});
        end
        @(posedge aclk);
        #1 s_axi_rvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq[0].size() != 0 || expq[1].size() != 0) && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        chk(name, 64'(expq[0].size() + expq[1].size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int base;
        logic done;
        out_cnt[0] = 0;
        out_cnt[1] = 0;
        areset_n      = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rdata   = '0;
        s_axi_rlast   = 1'b0;
        s_axi_rid     = '0;
        m_axis_tready = 2'b11;

        repeat (3) @(negedge aclk);
        chk("reset tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset count0", 64'(fifo_count[0]), 64'd0);
        chk("reset count1", 64'(fifo_count[1]), 64'd0);
        chk("reset err", 64'(err_overflow), 64'd0);
        @(posedge aclk);
        #1 areset_n = 1'b1;
        repeat (6) @(posedge aclk);
        #1;

        // Single beat on channel 1
        send(1, 32'hA5A5A5A5, 1'b1);
`ifdef AXI_READ_DEMUX_OUT_REG_EN
        @(negedge aclk);
        chk("single early tvalid1", 64'(m_axis_tvalid[1]), 64'd0);
`endif
        @(negedge aclk);
        chk("single tvalid1", 64'(m_axis_tvalid[1]), 64'd1);
        chk("single tdata1", 64'(m_axis_tdata[1]), 64'hA5A5A5A5);
        chk("single tlast1", 64'(m_axis_tlast[1]), 64'd1);
        chk("single tvalid0", 64'(m_axis_tvalid[0]), 64'd0);
        @(posedge aclk);
        #1;
        drain("single drain");

        // Interleaved rids
        send(0, 32'd1, 1'b0);
        send(1, 32'd2, 1'b0);
        send(0, 32'd3, 1'b1);
        send(1, 32'd4, 1'b1);
        drain("interleave drain");
        chk("interleave ch0 count", 64'(out_cnt[0]), 64'd2);
        chk("interleave ch1 count", 64'(out_cnt[1]), 64'd3);

        // Fill channel 0
        m_axis_tready[0] = 1'b0;
        for (int i = 0; i < 64; i++) send(0, 32'h100 + 32'(i), 1'b0);
        @(negedge aclk);
        chk("full count0", 64'(fifo_count[0]), 64'd64);
        s_axi_rid = 1'b0;
        #1 chk("full rready rid0", 64'(s_axi_rready), 64'd0);
        s_axi_rid = 1'b1;
        #1 chk("full rready rid1", 64'(s_axi_rready), 64'd1);
        @(posedge aclk);
        #1;
        chk("err before overflow", 64'(err_overflow), 64'd0);
        s_axi_rvalid = 1'b1;
        s_axi_rid    = 1'b0;
        s_axi_rdata  = 32'hDEAD;
        @(posedge aclk);
        #1 s_axi_rvalid = 1'b0;
        @(negedge aclk);
        chk("overflow err", 64'(err_overflow), 64'd1);
        chk("overflow count0", 64'(fifo_count[0]), 64'd64);
        @(posedge aclk);
        #1;

        // Full: blocked push while popping, then push accepted
        s_axi_rvalid     = 1'b1;
        s_axi_rid        = 1'b0;
        s_axi_rdata      = 32'h1000;
        s_axi_rlast      = 1'b1;
        m_axis_tready[0] = 1'b1;
        @(negedge aclk);
        chk("full pop rready", 64'(s_axi_rready), 64'd0);
        @(posedge aclk);
        #1 m_axis_tready[0] = 1'b0;
        @(negedge aclk);
        chk("after pop count0", 64'(fifo_count[0]), 64'd63);
        chk("after pop rready", 64'(s_axi_rready), 64'd1);
        if (s_axi_rready) expq[0].push_back({1'b1, 32'h1000});
        @(posedge aclk);
        #1 s_axi_rvalid = 1'b0;
        @(negedge aclk);
        chk("refill count0", 64'(fifo_count[0]), 64'd64);
        chk("err sticky", 64'(err_overflow), 64'd1);
        @(posedge aclk);
        #1 m_axis_tready[0] = 1'b1;
        drain("full drain");

        // 200 beats with tready toggling
        base = out_cnt[0];
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) send(0, 32'h2000 + 32'(i), 1'((i % 8) == 7));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge aclk);
                    #1 m_axis_tready[0] = ~m_axis_tready[0];
                end
            end
        join
        m_axis_tready[0] = 1'b1;
        drain("burst200 drain");
        chk("burst200 count", 64'(out_cnt[0] - base), 64'd200);
        chk("burst200 fifo empty", 64'(fifo_count[0]), 64'd0);

        // Reset with buffered beats
        m_axis_tready[0] = 1'b0;
        for (int i = 0; i < 10; i++) send(0, 32'h300 + 32'(i), 1'b0);
        @(negedge aclk);
        chk("pre-reset count0", 64'(fifo_count[0]), 64'd10);
        @(posedge aclk);
        #1 areset_n = 1'b0;
        #1;
        chk("async reset tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("async reset count0", 64'(fifo_count[0]), 64'd0);
        chk("async reset err", 64'(err_overflow), 64'd0);
        expq[0].delete();
        expq[1].delete();
        @(posedge aclk);
        #1 areset_n = 1'b1;
        m_axis_tready = 2'b11;
        base = out_cnt[0];
        send(0, 32'h55, 1'b1);
        drain("post-reset drain");
        repeat (4) @(negedge aclk);
        chk("post-reset count", 64'(out_cnt[0] - base), 64'd1);
        chk("post-reset idle", 64'(m_axis_tvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
